// File: rtl/freq_driver_multi.sv
// Multi-channel programmable square-wave divider with double-buffered half-periods.
// Optional phase-sync input is enabled by defining FREQ_DRV_PHASE_SYNC_EN.
module freq_driver_multi #(
    parameter int               CNT_W        = 32,
    parameter int               NCH          = 4,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = 32'd250000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             load,
    input  logic [3:0]       load_ch,
    input  logic [CNT_W-1:0] load_half,
`ifdef FREQ_DRV_PHASE_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   div_clk,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    logic [CNT_W-1:0] cnt_q  [NCH];
    logic [CNT_W-1:0] cnt_d  [NCH];
    logic [CNT_W-1:0] half_q [NCH];
    logic [CNT_W-1:0] half_d [NCH];
    logic [CNT_W-1:0] sh_q   [NCH];
    logic [CNT_W-1:0] sh_d   [NCH];
    logic [NCH-1:0]   div_q;
    logic [NCH-1:0]   div_d;
    logic [NCH-1:0]   tick_q;
    logic [NCH-1:0]   tick_d;
    logic [NCH-1:0]   pend_q;
    logic [NCH-1:0]   pend_d;
    logic             sync_s;

`ifdef FREQ_DRV_PHASE_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Per-channel next state: disable/sync/terminal-count handling, then shadow apply and load.
    always_comb begin
        logic apply_v;
        logic hit_v;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i]  = cnt_q[i];
            half_d[i] = half_q[i];
            sh_d[i]   = sh_q[i];
            div_d[i]  = div_q[i];
            tick_d[i] = 1'b0;
            pend_d[i] = pend_q[i];
            apply_v   = 1'b0;
            hit_v     = load && (load_ch == 4'(i));

            if (!en[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
                div_d[i] = 1'b0;
                apply_v  = pend_q[i];
            end else if (sync_s) begin
                cnt_d[i] = {CNT_W{1'b0}};
                div_d[i] = 1'b0;
                apply_v  = pend_q[i];
            end else if (cnt_q[i] == half_q[i]) begin
                // Only the falling toggle is a full-period boundary, so that is where a new N lands.
                cnt_d[i]  = {CNT_W{1'b0}};
                div_d[i]  = ~div_q[i];
                tick_d[i] = ~div_q[i];
                apply_v   = pend_q[i] & div_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (apply_v) begin
                half_d[i] = sh_q[i];
                pend_d[i] = 1'b0;
            end else begin
                half_d[i] = half_q[i];
            end

            // A load coinciding with an apply wins for sh/pending and waits one more period.
            if (hit_v) begin
                sh_d[i]   = load_half;
                pend_d[i] = 1'b1;
            end else begin
                sh_d[i] = sh_q[i];
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i]  <= {CNT_W{1'b0}};
                half_q[i] <= DEFAULT_HALF;
                sh_q[i]   <= DEFAULT_HALF;
            end
            div_q  <= {NCH{1'b0}};
            tick_q <= {NCH{1'b0}};
            pend_q <= {NCH{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            sh_q   <= sh_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign div_clk = div_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_freq_driver_multi.sv
// Scoreboard bench for freq_driver_multi (NCH=4, short DEFAULT_HALF for simulation speed).
module tb_freq_driver_multi;

    localparam int          NCH  = 4;
    localparam int          DEFN = 10;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             load;
    logic [3:0]       load_ch;
    logic [31:0]      load_half;
    logic             sync;
    logic [NCH-1:0]   div_clk;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;

    int tests_run = 0;
    int fails     = 0;

    typedef struct {
        logic [3:0] dv;
        logic [3:0] tk;
        logic [3:0] pd;
    } exp_t;

    exp_t sb[$];

    freq_driver_multi #(
        .CNT_W(32),
        .NCH(NCH),
        .DEFAULT_HALF(32'd10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .load(load),
        .load_ch(load_ch),
        .load_half(load_half),
`ifdef FREQ_DRV_PHASE_SYNC_EN
        .sync(sync),
`endif
        .div_clk(div_clk),
        .tick(tick),
        .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form waveform of a channel started from cnt=0/low, k edges later.
    function automatic logic exp_div(input int k, input int n);
        return ((k / (n + 1)) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int k, input int n);
        return (k > 0) && ((k % (2 * (n + 1))) == (n + 1));
    endfunction

    task automatic apply_reset(input logic [3:0] en_v);
        load = 1'b0; load_ch = 4'd0; load_half = 32'd0; sync = 1'b0;
        en = en_v;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; en = 4'h0; load = 1'b0; load_ch = 4'd0; load_half = 32'd0; sync = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            fails++;
            $display("FAIL reset: got div=%b tick=%b pend=%b, want all 0", div_clk, tick, pending);
        end
        e.dv = 4'h0; e.tk = 4'h0; e.pd = 4'h0;
        sb.push_back(e);
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        tests_run++;
        if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
            fails++;
            $display("FAIL reset_hold: got div=%b tick=%b pend=%b, want %b %b %b",
                     div_clk, tick, pending, e.dv, e.tk, e.pd);
        end
    endtask

    task automatic test_default_run();
        exp_t e;
        apply_reset(4'b0001);
        for (int k = 1; k <= 3 * 2 * (DEFN + 1); k++) begin
            e.dv = {3'b000, exp_div(k, DEFN)};
            e.tk = {3'b000, exp_tick(k, DEFN)};
            e.pd = 4'h0;
            sb.push_back(e);
        end
        for (int k = 1; k <= 3 * 2 * (DEFN + 1); k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL default_run k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
        end
    endtask

    task automatic test_load_midhigh();
        exp_t e;
        apply_reset(4'hF);
        // Load lands on edge 15 (ch2 high phase); falling toggle at edge 22 applies N=3.
        for (int k = 1; k <= 46; k++) begin
            logic a;
            a = exp_div(k, DEFN);
            e.dv = {a, (k < 22) ? a : exp_div(k - 22, 3), a, a};
            a = exp_tick(k, DEFN);
            e.tk = {a, (k < 22) ? a : exp_tick(k - 22, 3), a, a};
            e.pd = {1'b0, (k >= 15 && k < 22), 2'b00};
            sb.push_back(e);
        end
        for (int k = 1; k <= 46; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL load_midhigh k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
            if (k == 14) begin
                load = 1'b1; load_ch = 4'd2; load_half = 32'd3;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_n0_reload();
        exp_t e;
        apply_reset(4'h0);
        @(posedge clk); #1;
        load = 1'b1; load_ch = 4'd1; load_half = 32'd0;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (pending !== 4'h0) begin
            fails++;
            $display("FAIL disabled_apply: got pend=%b, want 0000", pending);
        end
        en = 4'b0010;
        // Reload on the apply edge (edge 2) must wait until edge 4.
        for (int k = 1; k <= 16; k++) begin
            e.dv = {2'b00, (k <= 4) ? exp_div(k, 0) : exp_div(k - 4, 1), 1'b0};
            e.tk = {2'b00, (k <= 4) ? exp_tick(k, 0) : exp_tick(k - 4, 1), 1'b0};
            e.pd = {2'b00, (k == 2 || k == 3), 1'b0};
            sb.push_back(e);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL n0_reload k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
            if (k == 1) begin
                load = 1'b1; load_ch = 4'd1; load_half = 32'd1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_double_load();
        exp_t e;
        apply_reset(4'hF);
        for (int k = 1; k <= 62; k++) begin
            logic a;
            a = exp_div(k, DEFN);
            e.dv = {(k < 22) ? a : exp_div(k - 22, 9), a, a, a};
            a = exp_tick(k, DEFN);
            e.tk = {(k < 22) ? a : exp_tick(k - 22, 9), a, a, a};
            e.pd = {(k >= 4 && k < 22), 3'b000};
            sb.push_back(e);
        end
        for (int k = 1; k <= 62; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL double_load k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
            case (k)
                3:       begin load = 1'b1; load_ch = 4'd3; load_half = 32'd5; end
                4:       begin load = 1'b1; load_ch = 4'd3; load_half = 32'd9; end
                5:       begin load = 1'b1; load_ch = 4'd7; load_half = 32'd2; end
                default: load = 1'b0;
            endcase
        end
    endtask

    task automatic test_disable_and_async_reset();
        exp_t e;
        apply_reset(4'b0001);
        for (int k = 1; k <= 34; k++) begin
            int j;
            j = k - 19;
            if (k <= 15) begin
                e.dv = {3'b000, exp_div(k, DEFN)};
                e.tk = {3'b000, exp_tick(k, DEFN)};
            end else if (k <= 19) begin
                e.dv = 4'h0;
                e.tk = 4'h0;
            end else begin
                e.dv = {3'b000, exp_div(j, DEFN)};
                e.tk = {3'b000, exp_tick(j, DEFN)};
            end
            e.pd = {3'b000, (k > 19 && j >= 13 && j < 22)};
            sb.push_back(e);
        end
        for (int k = 1; k <= 34; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL disable k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
            load = 1'b0;
            if (k == 15) en = 4'b0000;
            if (k == 19) en = 4'b0001;
            if (k == 31) begin
                load = 1'b1; load_ch = 4'd0; load_half = 32'd2;
            end
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({div_clk, tick, pending} !== 12'h000) begin
            fails++;
            $display("FAIL async_reset: got div=%b tick=%b pend=%b, want all 0", div_clk, tick, pending);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

`ifdef FREQ_DRV_PHASE_SYNC_EN
    task automatic test_sync();
        exp_t e;
        apply_reset(4'h0);
        @(posedge clk); #1;
        load = 1'b1; load_ch = 4'd0; load_half = 32'd4;
        @(posedge clk); #1;
        load_ch = 4'd1;
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        en = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        en = 4'b0011;
        repeat (3) @(posedge clk);
        #1;
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        tests_run++;
        if (div_clk !== 4'h0) begin
            fails++;
            $display("FAIL sync_clear: got div=%b, want 0000", div_clk);
        end
        for (int k = 1; k <= 20; k++) begin
            e.dv = {2'b00, exp_div(k, 4), exp_div(k, 4)};
            e.tk = {2'b00, exp_tick(k, 4), exp_tick(k, 4)};
            e.pd = 4'h0;
            sb.push_back(e);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front();
            tests_run++;
            if (div_clk !== e.dv || tick !== e.tk || pending !== e.pd) begin
                fails++;
                $display("FAIL sync k=%0d: got div=%b tick=%b pend=%b, want %b %b %b",
                         k, div_clk, tick, pending, e.dv, e.tk, e.pd);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_load_midhigh();
        test_n0_reload();
        test_double_load();
        test_disable_and_async_reset();
`ifdef FREQ_DRV_PHASE_SYNC_EN
        test_sync();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
